// File: rtl/execute_stage_if.sv
// Y86-64 execute-stage bus bundle: E-register fields in, forwarding and M-register fields out.
// The master side drives the E fields and stage status, and the slave side is the execute stage.
interface execute_stage_if #(
  parameter int W = 64
);
  // Fields from the E pipeline register, plus downstream status and bubble control
  logic [3:0]   E_stat;
  logic [3:0]   E_icode;
  logic [3:0]   E_ifun;
  logic [W-1:0] E_valA;
  logic [W-1:0] E_valB;
  logic [W-1:0] E_valC;
  logic [3:0]   E_dstE;
  logic [3:0]   E_dstM;
  logic [3:0]   m_stat;
  logic [3:0]   W_stat;
  logic         M_bubble;

  // Combinational forwarding outputs
  logic [W-1:0] e_valE;
  logic         e_Cnd;
  logic [3:0]   e_dstE;

  // Registered condition codes
  logic         cc_zf;
  logic         cc_sf;
  logic         cc_of;

  // Fields of the M pipeline register
  logic [3:0]   M_stat;
  logic [3:0]   M_icode;
  logic         M_Cnd;
  logic [W-1:0] M_valE;
  logic [W-1:0] M_valA;
  logic [3:0]   M_dstE;
  logic [3:0]   M_dstM;

  modport master (
    output E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
    output m_stat, W_stat, M_bubble,
    input  e_valE, e_Cnd, e_dstE, cc_zf, cc_sf, cc_of,
    input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
  );

  modport slave (
    input  E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
    input  m_stat, W_stat, M_bubble,
    output e_valE, e_Cnd, e_dstE, cc_zf, cc_sf, cc_of,
    output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
  );
endinterface

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, branch/cmov condition and the M pipeline register.
module execute_stage #(
  parameter int W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  execute_stage_if.slave       bus
);

  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] I_NOP    = 4'h1;

  localparam logic [3:0] S_AOK    = 4'h1;
  localparam logic [3:0] R_NONE   = 4'hF;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_XOR  = 4'h3;

  // Stack pointer adjustment constants; -8 is the two's complement of 8.
  localparam logic [W-1:0] POS8 = W'(8);
  localparam logic [W-1:0] NEG8 = ~W'(7);

  logic [W-1:0] alu_a, alu_b, alu_r;
  logic [3:0]   alu_fun;
  logic         new_zf, new_sf, new_of;
  logic         set_cc;
  logic         cnd;
  logic [3:0]   dst_e;

  logic         cc_zf_d, cc_sf_d, cc_of_d;
  logic         cc_zf_q, cc_sf_q, cc_of_q;

  logic [3:0]   mr_stat_d, mr_icode_d, mr_dste_d, mr_dstm_d;
  logic [3:0]   mr_stat_q, mr_icode_q, mr_dste_q, mr_dstm_q;
  logic         mr_cnd_d, mr_cnd_q;
  logic [W-1:0] mr_vale_d, mr_vala_d;
  logic [W-1:0] mr_vale_q, mr_vala_q;

  // Operand selection and ALU function; only OPq uses ifun, everything else adds.
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    unique case (bus.E_icode)
      I_RRMOVQ, I_OPQ:             alu_a = bus.E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = bus.E_valC;
      I_CALL, I_PUSHQ:             alu_a = NEG8;
      I_RET, I_POPQ:               alu_a = POS8;
      default:                     alu_a = '0;
    endcase
    unique case (bus.E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = bus.E_valB;
      default:                                                  alu_b = '0;
    endcase
    alu_fun = (bus.E_icode == I_OPQ) ? bus.E_ifun : ALU_ADD;
  end

  // ALU result and the flags it would write; undefined OPq functions yield zero.
  always_comb begin
    alu_r  = '0;
    new_of = 1'b0;
    unique case (alu_fun)
      ALU_ADD: begin
        alu_r  = alu_b + alu_a;
        new_of = (alu_a[W-1] == alu_b[W-1]) && (alu_r[W-1] != alu_b[W-1]);
      end
      ALU_SUB: begin
        alu_r  = alu_b - alu_a;
        new_of = (alu_a[W-1] != alu_b[W-1]) && (alu_r[W-1] != alu_b[W-1]);
      end
      ALU_AND: alu_r = alu_b & alu_a;
      ALU_XOR: alu_r = alu_b ^ alu_a;
      default: alu_r = '0;
    endcase
    new_zf = (alu_r == '0);
    new_sf = alu_r[W-1];
  end

  // Only an OPq updates CC, and only while nothing downstream has faulted.
  always_comb begin
    set_cc  = (bus.E_icode == I_OPQ) && (bus.m_stat == S_AOK) && (bus.W_stat == S_AOK);
    cc_zf_d = cc_zf_q;
    cc_sf_d = cc_sf_q;
    cc_of_d = cc_of_q;
    if (set_cc) begin
      cc_zf_d = new_zf;
      cc_sf_d = new_sf;
      cc_of_d = new_of;
    end
  end

  // Condition from the registered CC, so a cmov/jXX sees what the previous OPq wrote.
  always_comb begin
    cnd = 1'b0;
    unique case (bus.E_ifun)
      4'h0:    cnd = 1'b1;
      4'h1:    cnd = (cc_sf_q ^ cc_of_q) | cc_zf_q;
      4'h2:    cnd = cc_sf_q ^ cc_of_q;
      4'h3:    cnd = cc_zf_q;
      4'h4:    cnd = ~cc_zf_q;
      4'h5:    cnd = ~(cc_sf_q ^ cc_of_q);
      4'h6:    cnd = ~(cc_sf_q ^ cc_of_q) & ~cc_zf_q;
      default: cnd = 1'b0;
    endcase
    dst_e = ((bus.E_icode == I_RRMOVQ) && !cnd) ? R_NONE : bus.E_dstE;
  end

  // Next M register contents: bubble or the instruction leaving execute.
  always_comb begin
    if (bus.M_bubble) begin
      mr_stat_d  = S_AOK;
      mr_icode_d = I_NOP;
      mr_cnd_d   = 1'b0;
      mr_vale_d  = '0;
      mr_vala_d  = '0;
      mr_dste_d  = R_NONE;
      mr_dstm_d  = R_NONE;
    end else begin
      mr_stat_d  = bus.E_stat;
      mr_icode_d = bus.E_icode;
      mr_cnd_d   = cnd;
      mr_vale_d  = alu_r;
      mr_vala_d  = bus.E_valA;
      mr_dste_d  = dst_e;
      mr_dstm_d  = bus.E_dstM;
    end
  end

  // State update; reset discards the in-flight instruction and restores ZF=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_zf_q    <= 1'b1;
      cc_sf_q    <= 1'b0;
      cc_of_q    <= 1'b0;
      mr_stat_q  <= S_AOK;
      mr_icode_q <= I_NOP;
      mr_cnd_q   <= 1'b0;
      mr_vale_q  <= '0;
      mr_vala_q  <= '0;
      mr_dste_q  <= R_NONE;
      mr_dstm_q  <= R_NONE;
    end else begin
      cc_zf_q    <= cc_zf_d;
      cc_sf_q    <= cc_sf_d;
      cc_of_q    <= cc_of_d;
      mr_stat_q  <= mr_stat_d;
      mr_icode_q <= mr_icode_d;
      mr_cnd_q   <= mr_cnd_d;
      mr_vale_q  <= mr_vale_d;
      mr_vala_q  <= mr_vala_d;
      mr_dste_q  <= mr_dste_d;
      mr_dstm_q  <= mr_dstm_d;
    end
  end

  assign bus.e_valE  = alu_r;
  assign bus.e_Cnd   = cnd;
  assign bus.e_dstE  = dst_e;
  assign bus.cc_zf   = cc_zf_q;
  assign bus.cc_sf   = cc_sf_q;
  assign bus.cc_of   = cc_of_q;
  assign bus.M_stat  = mr_stat_q;
  assign bus.M_icode = mr_icode_q;
  assign bus.M_Cnd   = mr_cnd_q;
  assign bus.M_valE  = mr_vale_q;
  assign bus.M_valA  = mr_vala_q;
  assign bus.M_dstE  = mr_dste_q;
  assign bus.M_dstM  = mr_dstm_q;

endmodule

// File: tb/tb_execute_stage.sv
// Testbench for execute_stage: directed Y86-64 cases followed by random instructions against a reference model.
module tb_execute_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  execute_stage_if #(.W(64)) ex_if ();

  execute_stage #(.W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ex_if)
  );

  always #5 clk = ~clk;

  // Reference architectural state
  logic       m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0;
  logic [3:0] m_stat, m_icode, m_dste, m_dstm;
  logic       m_cnd;
  logic [63:0] m_vale, m_vala;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Y86 semantics computed directly from what each instruction means.
  function automatic logic [63:0] ref_val(input logic [3:0] ic, input logic [3:0] fn,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c, output logic of);
    logic signed [64:0] wide;
    logic [63:0] r;
    r  = 64'd0;
    of = 1'b0;
    case (ic)
      4'h2:       r = a;
      4'h3:       r = c;
      4'h4, 4'h5: r = b + c;
      4'h8, 4'hA: r = b - 64'd8;
      4'h9, 4'hB: r = b + 64'd8;
      4'h6: begin
        case (fn)
          4'h0: begin
            wide = $signed({b[63], b}) + $signed({a[63], a});
            r    = wide[63:0];
            of   = wide[64] != wide[63];
          end
          4'h1: begin
            wide = $signed({b[63], b}) - $signed({a[63], a});
            r    = wide[63:0];
            of   = wide[64] != wide[63];
          end
          4'h2:    r = b & a;
          4'h3:    r = b ^ a;
          default: r = 64'd0;
        endcase
      end
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  function automatic logic ref_cond(input logic [3:0] fn, input logic zf, input logic sf, input logic of);
    logic less;
    less = (sf != of);
    case (fn)
      4'h0:    return 1'b1;
      4'h1:    return less || zf;
      4'h2:    return less;
      4'h3:    return zf;
      4'h4:    return !zf;
      4'h5:    return !less;
      4'h6:    return !less && !zf;
      default: return 1'b0;
    endcase
  endfunction

  // One instruction through execute: check forwarding outputs, clock, then check M and CC.
  task automatic apply(input logic r, input logic [3:0] st, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                       input logic [3:0] de, input logic [3:0] dm, input logic [3:0] ms,
                       input logic [3:0] ws, input logic bub);
    logic [63:0] ev;
    logic        eof, ecnd;
    logic [3:0]  edst;
    @(negedge clk);
    rst            = r;
    ex_if.E_stat   = st;
    ex_if.E_icode  = ic;
    ex_if.E_ifun   = fn;
    ex_if.E_valA   = va;
    ex_if.E_valB   = vb;
    ex_if.E_valC   = vc;
    ex_if.E_dstE   = de;
    ex_if.E_dstM   = dm;
    ex_if.m_stat   = ms;
    ex_if.W_stat   = ws;
    ex_if.M_bubble = bub;
    ev   = ref_val(ic, fn, va, vb, vc, eof);
    ecnd = ref_cond(fn, m_zf, m_sf, m_of);
    edst = (ic == 4'h2 && !ecnd) ? 4'hF : de;
    #1;
    chk("e_valE", ex_if.e_valE, ev);
    chk("e_Cnd", 64'(ex_if.e_Cnd), 64'(ecnd));
    chk("e_dstE", 64'(ex_if.e_dstE), 64'(edst));
    @(posedge clk);
    #1;
    if (r) begin
      {m_zf, m_sf, m_of} = 3'b100;
    end else if (ic == 4'h6 && ms == 4'h1 && ws == 4'h1) begin
      m_zf = (ev == 64'd0);
      m_sf = ev[63];
      m_of = eof;
    end
    if (r || bub) begin
      m_stat = 4'h1; m_icode = 4'h1; m_cnd = 1'b0; m_vale = 64'd0; m_vala = 64'd0;
      m_dste = 4'hF; m_dstm = 4'hF;
    end else begin
      m_stat = st; m_icode = ic; m_cnd = ecnd; m_vale = ev; m_vala = va;
      m_dste = edst; m_dstm = dm;
    end
    chk("M_stat", 64'(ex_if.M_stat), 64'(m_stat));
    chk("M_icode", 64'(ex_if.M_icode), 64'(m_icode));
    chk("M_Cnd", 64'(ex_if.M_Cnd), 64'(m_cnd));
    chk("M_valE", ex_if.M_valE, m_vale);
    chk("M_valA", ex_if.M_valA, m_vala);
    chk("M_dstE", 64'(ex_if.M_dstE), 64'(m_dste));
    chk("M_dstM", 64'(ex_if.M_dstM), 64'(m_dstm));
    chk("cc_zf", 64'(ex_if.cc_zf), 64'(m_zf));
    chk("cc_sf", 64'(ex_if.cc_sf), 64'(m_sf));
    chk("cc_of", 64'(ex_if.cc_of), 64'(m_of));
  endtask

  // Linear directed sequence, then randomized instruction stream.
  initial begin
    logic [3:0]  r_ic, r_fn, r_ms, r_ws;
    logic [63:0] r_a, r_b, r_c;

    // Reset state
    apply(1'b1, 4'h1, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 4'h1, 4'h1, 1'b0);
    chk("rst_M_icode", 64'(ex_if.M_icode), 64'h1);
    chk("rst_M_dstE", 64'(ex_if.M_dstE), 64'hF);
    chk("rst_cc_zf", 64'(ex_if.cc_zf), 64'h1);

    // OPq add with signed overflow
    apply(1'b0, 4'h1, 4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h2, 4'hF, 4'h1, 4'h1, 1'b0);
    chk("add_M_valE", ex_if.M_valE, 64'h8000_0000_0000_0000);
    chk("add_cc", 64'({ex_if.cc_zf, ex_if.cc_sf, ex_if.cc_of}), 64'b011);
    chk("add_M_dstE", 64'(ex_if.M_dstE), 64'h2);

    // OPq sub to zero, then cmove and cmovne
    apply(1'b0, 4'h1, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h2, 4'hF, 4'h1, 4'h1, 1'b0);
    chk("sub_cc", 64'({ex_if.cc_zf, ex_if.cc_sf, ex_if.cc_of}), 64'b100);
    apply(1'b0, 4'h1, 4'h2, 4'h3, 64'h55, 64'd0, 64'd0, 4'h3, 4'hF, 4'h1, 4'h1, 1'b0);
    chk("cmove_M_dstE", 64'(ex_if.M_dstE), 64'h3);
    apply(1'b0, 4'h1, 4'h2, 4'h4, 64'h55, 64'd0, 64'd0, 4'h3, 4'hF, 4'h1, 4'h1, 1'b0);
    chk("cmovne_M_dstE", 64'(ex_if.M_dstE), 64'hF);

    // set_cc gating: nonzero-producing sub must not overwrite ZF=1
    apply(1'b0, 4'h1, 4'h6, 4'h1, 64'd1, 64'd9, 64'd0, 4'h2, 4'hF, 4'h3, 4'h1, 1'b0);
    chk("gate_m_zf", 64'(ex_if.cc_zf), 64'h1);
    apply(1'b0, 4'h1, 4'h6, 4'h1, 64'd1, 64'd9, 64'd0, 4'h2, 4'hF, 4'h1, 4'h2, 1'b0);
    chk("gate_w_zf", 64'(ex_if.cc_zf), 64'h1);

    // Stack and address arithmetic
    apply(1'b0, 4'h1, 4'hA, 4'h0, 64'd7, 64'h100, 64'd0, 4'h4, 4'hF, 4'h1, 4'h1, 1'b0);
    chk("pushq_valE", ex_if.M_valE, 64'hF8);
    apply(1'b0, 4'h1, 4'h8, 4'h0, 64'd0, 64'h100, 64'h40, 4'h4, 4'hF, 4'h1, 4'h1, 1'b0);
    chk("call_valE", ex_if.M_valE, 64'hF8);
    apply(1'b0, 4'h1, 4'h9, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4, 4'hF, 4'h1, 4'h1, 1'b0);
    chk("ret_valE", ex_if.M_valE, 64'h108);
    apply(1'b0, 4'h1, 4'hB, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4, 4'h5, 4'h1, 4'h1, 1'b0);
    chk("popq_valE", ex_if.M_valE, 64'h108);
    apply(1'b0, 4'h1, 4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 4'h6, 4'hF, 4'h1, 4'h1, 1'b0);
    chk("irmovq_valE", ex_if.M_valE, 64'h1234);
    apply(1'b0, 4'h1, 4'h4, 4'h0, 64'd3, 64'h100, 64'd8, 4'hF, 4'hF, 4'h1, 4'h1, 1'b0);
    chk("rmmovq_valE", ex_if.M_valE, 64'h108);

    // Bubble with an OPq in E: M is bubbled, CC still updates (sub 3-5 -> negative)
    apply(1'b0, 4'h1, 4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 4'h2, 4'h7, 4'h1, 4'h1, 1'b1);
    chk("bub_M_icode", 64'(ex_if.M_icode), 64'h1);
    chk("bub_M_dstM", 64'(ex_if.M_dstM), 64'hF);
    chk("bub_cc", 64'({ex_if.cc_zf, ex_if.cc_sf, ex_if.cc_of}), 64'b010);

    // Mid-stream reset with an OPq in E, then jle / jl
    apply(1'b1, 4'h1, 4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 4'h2, 4'hF, 4'h1, 4'h1, 1'b0);
    chk("rst2_cc", 64'({ex_if.cc_zf, ex_if.cc_sf, ex_if.cc_of}), 64'b100);
    apply(1'b0, 4'h1, 4'h7, 4'h1, 64'd0, 64'd0, 64'h200, 4'hF, 4'hF, 4'h1, 4'h1, 1'b0);
    chk("jle_M_Cnd", 64'(ex_if.M_Cnd), 64'h1);
    apply(1'b0, 4'h1, 4'h7, 4'h2, 64'd0, 64'd0, 64'h200, 4'hF, 4'hF, 4'h1, 4'h1, 1'b0);
    chk("jl_M_Cnd", 64'(ex_if.M_Cnd), 64'h0);

    // Random instruction stream
    for (int i = 0; i < 300; i++) begin
      r_ic = ($urandom_range(0, 2) == 0) ? 4'h6 : 4'($urandom_range(0, 15));
      r_fn = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      r_a  = {$urandom, $urandom};
      r_b  = ($urandom_range(0, 3) == 0) ? r_a : {$urandom, $urandom};
      r_c  = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 255)) : {$urandom, $urandom};
      r_ms = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 4)) : 4'h1;
      r_ws = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 4)) : 4'h1;
      apply(($urandom_range(0, 39) == 0), 4'($urandom_range(1, 4)), r_ic, r_fn, r_a, r_b, r_c,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), r_ms, r_ws,
            ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
